equiv_monitor: RTL and testbench
================================

# equiv_monitor

Parametrised equivalence monitor for the fuzz/equivalence harness: compares CHANNELS output buses from two implementations of the same design every clock and flags divergence. Each side has its own latency-alignment delay line, and a warm-up window suppresses reset transients. The monitor keeps a sticky fail flag and a saturating mismatch counter, and captures diagnostics for the first divergence. It sits in the harness top between the two DUT instances and the formal/simulation checker.

## Interface
- WIDTH, 91: bits per channel.
- CHANNELS, 2: number of compared buses; channel c occupies bits [c*WIDTH +: WIDTH].
- DELAY_A, 0: pipeline stages applied to y_a (0..15).
- DELAY_B, 0: pipeline stages applied to y_b (0..15).
- WARMUP, 4: edges after reset before comparison is armed, excluding delay fill.
- CNT_W, 16: mismatch counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  current y_a/y_b sample is meaningful.
- chan_mask  in  CHANNELS  1 = channel compared. Sampled at the compare stage, not delayed.
- y_a  in  CHANNELS*WIDTH  implementation A outputs.
- y_b  in  CHANNELS*WIDTH  implementation B outputs.
- armed  out  1  comparison enabled.
- fail  out  1  sticky; a mismatch has occurred since reset.
- mismatch_cnt  out  CNT_W  cycles with at least one mismatch.
- first_chan  out  max(1,$clog2(CHANNELS))  lowest mismatching channel at first failure.
- first_cycle  out  32  cycle counter value at first failure.
- first_a  out  WIDTH  channel value from side A at first failure.
- first_b  out  WIDTH  channel value from side B at first failure.

## Operation
- Let D = max(DELAY_A, DELAY_B).
- Delay lines: y_a passes through DELAY_A registers and y_b through DELAY_B registers. valid passes through D registers. All delay registers shift every edge, independent of valid. A delay of 0 means a combinational path to the compare stage.
- Compare stage: per channel c, mm[c] = (a_d[c] != b_d[c]) & chan_mask[c]. hit = armed & valid_d & |mm.
- Cycle counter cyc is 32 bits. It clears on rst and increments each edge, wrapping at 2^32.
- armed = 0 until cyc >= WARMUP + D, then 1 until the next reset.
- On an edge with hit:
  - mismatch_cnt increments by 1 per cycle, not per channel, and saturates at all-ones.
  - fail is set.
  - If fail was 0 before this edge, capture first_chan = lowest c with mm[c] = 1, first_cycle = cyc, first_a = a_d[c], first_b = b_d[c].
- Capture registers hold until reset; later mismatches never overwrite them.
- Reset behaviour: rst (including mid-run) clears delay lines, valid pipe, cyc, armed, fail, mismatch_cnt and all first_* to 0 on the same edge. Compare is disabled on that edge.
- X/Z on inputs is not filtered; the team relies on delay-line reset to 0 to keep the armed window clean.

## Timing
- All outputs are registered. Every output reads 0 after a reset edge.
- Latency: a mismatch presented at y_a on edge k and y_b on edge k + DELAY_A − DELAY_B, with valid at edge k + DELAY_A − D, reaches the compare stage in the cycle after edge k + DELAY_A. fail/cnt/first_* update on edge k + DELAY_A + 1.
- With DELAY_A = DELAY_B = 0: inputs set before edge k produce fail = 1 after edge k.
- armed rises on the edge where cyc transitions to WARMUP + D. A mismatch in that same cycle, before the edge, is not counted.
- Simultaneous first hit on several channels: only the lowest index is captured; the counter increments once.
- Counter saturation does not affect fail or the capture registers.

## Configuration
- EQUIV_ASSERT_EN defined: adds an immediate assertion, checked on every clk rising edge, that !(~rst & hit). It is used by formal equivalence (SBY) and simulation to stop at the first divergence.
- EQUIV_ASSERT_EN undefined: no assertion is emitted. Output behaviour is identical in both cases.

## Test plan
- Reset and warm-up: WARMUP=4, delays 0, y_a ≠ y_b from reset release. armed rises after 4 edges, no hit before that. fail=1 and mismatch_cnt=1 after edge 5; first_cycle=4.
- Alignment: DELAY_A=2, DELAY_B=0, y_b = y_a delayed by 2 cycles, random data for 100 cycles. fail stays 0. Setting DELAY_A=1 produces fail=1 on the first armed valid cycle where the data differs.
- Multi-channel capture: CHANNELS=2, channel 1 mismatches at cyc=10 with a=0x5, b=0x7, then channel 0 mismatches at cyc=12. Expected first_chan=1, first_a=5, first_b=7, first_cycle=10, mismatch_cnt=2.
- Masking and valid: a mismatch on a masked channel, or with valid=0, leaves fail=0 and cnt=0.
- Saturation: CNT_W=3, 10 consecutive mismatch cycles. mismatch_cnt reads 7 and holds; capture stays at the first event.
- Mid-run reset: after fail=1, assert rst for 1 cycle. All outputs read 0 and armed re-rises WARMUP+D edges later.

Source files
------------

// File: rtl/equiv_monitor_if.sv
// Bus bundle between the harness and equiv_monitor: compared samples in, verdict and
// first-divergence diagnostics out.
interface equiv_monitor_if #(
  parameter int unsigned WIDTH    = 91,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      valid;
  logic [CHANNELS-1:0]       chan_mask;
  logic [CHANNELS*WIDTH-1:0] y_a;
  logic [CHANNELS*WIDTH-1:0] y_b;

  logic                      armed;
  logic                      fail;
  logic [CNT_W-1:0]          mismatch_cnt;
  logic [CHAN_W-1:0]         first_chan;
  logic [31:0]               first_cycle;
  logic [WIDTH-1:0]          first_a;
  logic [WIDTH-1:0]          first_b;

  modport master (
    output valid, chan_mask, y_a, y_b,
    input  armed, fail, mismatch_cnt, first_chan, first_cycle, first_a, first_b
  );

  modport slave (
    input  valid, chan_mask, y_a, y_b,
    output armed, fail, mismatch_cnt, first_chan, first_cycle, first_a, first_b
  );
endinterface

// File: rtl/equiv_monitor.sv
// Equivalence monitor: aligns two implementations' buses, compares them per channel and
// records the first divergence. Define EQUIV_ASSERT_EN to add an assertion on divergence.
module equiv_monitor #(
  parameter int unsigned WIDTH    = 91,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DELAY_A  = 0,
  parameter int unsigned DELAY_B  = 0,
  parameter int unsigned WARMUP   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  equiv_monitor_if.slave mon
);
  localparam int unsigned BUS_W  = CHANNELS * WIDTH;
  localparam int unsigned D      = (DELAY_A > DELAY_B) ? DELAY_A : DELAY_B;
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ARM_AT = WARMUP + D;

  // Encoding chosen so bit 0 is the armed flag and bit 1 the sticky fail flag.
  typedef enum logic [1:0] {
    S_WARM   = 2'b00,
    S_ARMED  = 2'b01,
    S_FAILED = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cyc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHAN_W-1:0] fchan_q, fchan_d;
  logic [31:0]       fcyc_q, fcyc_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fb_q, fb_d;

  logic [BUS_W-1:0]    a_d, b_d;
  logic                valid_d;
  logic [CHANNELS-1:0] mm_c;
  logic                hit_c;
  logic [CHAN_W-1:0]   low_c;
  logic [WIDTH-1:0]    low_a_c, low_b_c;

  // Side A alignment delay line
  generate
    if (DELAY_A == 0) begin : g_a_comb
      assign a_d = mon.y_a;
    end else begin : g_a_pipe
      logic [BUS_W-1:0] pipe [DELAY_A];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY_A; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mon.y_a;
          for (int i = 1; i < DELAY_A; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign a_d = pipe[DELAY_A-1];
    end
  endgenerate

  // Side B alignment delay line
  generate
    if (DELAY_B == 0) begin : g_b_comb
      assign b_d = mon.y_b;
    end else begin : g_b_pipe
      logic [BUS_W-1:0] pipe [DELAY_B];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY_B; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mon.y_b;
          for (int i = 1; i < DELAY_B; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign b_d = pipe[DELAY_B-1];
    end
  endgenerate

  // valid follows the longer of the two paths
  generate
    if (D == 0) begin : g_v_comb
      assign valid_d = mon.valid;
    end else begin : g_v_pipe
      logic [D-1:0] pipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe <= '0;
        end else begin
          pipe[0] <= mon.valid;
          for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign valid_d = pipe[D-1];
    end
  endgenerate

  // Per-channel compare; chan_mask applies at this stage without delay
  always_comb begin
    mm_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mm_c[c] = (a_d[c*WIDTH +: WIDTH] != b_d[c*WIDTH +: WIDTH]) & mon.chan_mask[c];
    end
  end

  assign hit_c = state_q[0] & valid_d & (|mm_c);

  // Lowest mismatching channel and its two values
  always_comb begin
    low_c   = '0;
    low_a_c = '0;
    low_b_c = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (mm_c[c]) begin
        low_c   = CHAN_W'(c);
        low_a_c = a_d[c*WIDTH +: WIDTH];
        low_b_c = b_d[c*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: arming, sticky fail, saturating count, first-hit capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fchan_d = fchan_q;
    fcyc_d  = fcyc_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    case (state_q)
      S_WARM: begin
        if (({1'b0, cyc_q} + 33'd1) >= 33'(ARM_AT)) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (hit_c) state_d = S_FAILED;
      end
      S_FAILED: begin
        state_d = S_FAILED;
      end
      default: begin
        state_d = S_WARM;
      end
    endcase

    if (hit_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    if (hit_c && (state_q == S_ARMED)) begin
      fchan_d = low_c;
      fcyc_d  = cyc_q;
      fa_d    = low_a_c;
      fb_d    = low_b_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WARM;
      cyc_q   <= '0;
      cnt_q   <= '0;
      fchan_q <= '0;
      fcyc_q  <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_q + 32'd1;
      cnt_q   <= cnt_d;
      fchan_q <= fchan_d;
      fcyc_q  <= fcyc_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign mon.armed        = state_q[0];
  assign mon.fail         = state_q[1];
  assign mon.mismatch_cnt = cnt_q;
  assign mon.first_chan   = fchan_q;
  assign mon.first_cycle  = fcyc_q;
  assign mon.first_a      = fa_q;
  assign mon.first_b      = fb_q;

`ifdef EQUIV_ASSERT_EN
  always @(posedge clk) begin
    assert (!(!rst && hit_c))
      else $error("equiv_monitor: divergence at cycle %0d channel %0d", cyc_q, low_c);
  end
`endif

endmodule

// File: tb/tb_equiv_monitor.sv
// Bench for equiv_monitor: three instances (zero-delay, aligned, misaligned) checked every
// cycle against a history-based reference model plus directed scenario checks.
module tb_equiv_monitor;
  localparam int unsigned W  = 91;
  localparam int unsigned BW = 2 * W;
  localparam int unsigned WU = 4;
  localparam int unsigned HN = 512;

  logic clk = 1'b0;
  logic rst0, rst12;
  always #5 clk = ~clk;

  equiv_monitor_if #(.WIDTH(W), .CHANNELS(2), .CNT_W(3))  if0 ();
  equiv_monitor_if #(.WIDTH(W), .CHANNELS(2), .CNT_W(16)) if1 ();
  equiv_monitor_if #(.WIDTH(W), .CHANNELS(2), .CNT_W(16)) if2 ();

  equiv_monitor #(.WIDTH(W), .CHANNELS(2), .DELAY_A(0), .DELAY_B(0), .WARMUP(WU), .CNT_W(3))
    u0 (.clk(clk), .rst(rst0), .mon(if0));
  equiv_monitor #(.WIDTH(W), .CHANNELS(2), .DELAY_A(2), .DELAY_B(0), .WARMUP(WU), .CNT_W(16))
    u1 (.clk(clk), .rst(rst12), .mon(if1));
  equiv_monitor #(.WIDTH(W), .CHANNELS(2), .DELAY_A(1), .DELAY_B(0), .WARMUP(WU), .CNT_W(16))
    u2 (.clk(clk), .rst(rst12), .mon(if2));

  int unsigned da [3] = '{0, 2, 1};
  int unsigned db [3] = '{0, 0, 0};
  int unsigned cw [3] = '{3, 16, 16};

  // Reference model: input history since last reset, indexed by cycle number
  logic [BW-1:0] ha [3][HN];
  logic [BW-1:0] hb [3][HN];
  bit            hv [3][HN];
  int unsigned   m_cyc [3];
  bit            m_fail [3];
  int unsigned   m_cnt [3];
  int unsigned   m_fchan [3];
  int unsigned   m_fcyc [3];
  logic [W-1:0]  m_fa [3];
  logic [W-1:0]  m_fb [3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [BW-1:0] rand_bus();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  function automatic logic [W-1:0] rand_ch();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge given the inputs presented in this cycle
  task automatic model_edge(input int k, input bit r, input logic [BW-1:0] ya,
                            input logic [BW-1:0] yb, input bit v, input logic [1:0] mask);
    int unsigned c, d;
    logic [BW-1:0] ad, bd;
    bit vd, hit;
    int first;
    if (r) begin
      m_cyc[k] = 0; m_fail[k] = 0; m_cnt[k] = 0;
      m_fchan[k] = 0; m_fcyc[k] = 0; m_fa[k] = '0; m_fb[k] = '0;
    end else begin
      c  = m_cyc[k];
      d  = (da[k] > db[k]) ? da[k] : db[k];
      ad = (da[k] == 0) ? ya : ((c >= da[k]) ? ha[k][c - da[k]] : '0);
      bd = (db[k] == 0) ? yb : ((c >= db[k]) ? hb[k][c - db[k]] : '0);
      vd = (d == 0) ? v : ((c >= d) ? hv[k][c - d] : 1'b0);
      first = -1;
      for (int ch = 0; ch < 2; ch++)
        if (first < 0 && mask[ch] && (ad[ch*W +: W] !== bd[ch*W +: W])) first = ch;
      hit = (c >= WU + d) && vd && (first >= 0);
      if (hit) begin
        if (m_cnt[k] < (32'd1 << cw[k]) - 1) m_cnt[k]++;
        if (!m_fail[k]) begin
          m_fchan[k] = first;
          m_fcyc[k]  = c;
          m_fa[k]    = ad[first*W +: W];
          m_fb[k]    = bd[first*W +: W];
        end
        m_fail[k] = 1'b1;
      end
      ha[k][c] = ya; hb[k][c] = yb; hv[k][c] = v;
      m_cyc[k] = c + 1;
    end
  endtask

  task automatic check_inst(input int k, input logic armed, input logic fail,
                            input logic [31:0] cnt, input logic [31:0] fchan,
                            input logic [31:0] fcyc, input logic [W-1:0] fa,
                            input logic [W-1:0] fb);
    int unsigned d;
    d = (da[k] > db[k]) ? da[k] : db[k];
    chk($sformatf("u%0d.armed@%0d", k, m_cyc[k]), BW'(armed), BW'(m_cyc[k] >= WU + d));
    chk($sformatf("u%0d.fail@%0d", k, m_cyc[k]), BW'(fail), BW'(m_fail[k]));
    chk($sformatf("u%0d.cnt@%0d", k, m_cyc[k]), BW'(cnt), BW'(m_cnt[k]));
    chk($sformatf("u%0d.first_chan", k), BW'(fchan), BW'(m_fchan[k]));
    chk($sformatf("u%0d.first_cycle", k), BW'(fcyc), BW'(m_fcyc[k]));
    chk($sformatf("u%0d.first_a", k), BW'(fa), BW'(m_fa[k]));
    chk($sformatf("u%0d.first_b", k), BW'(fb), BW'(m_fb[k]));
  endtask

  task automatic drive0(input bit v, input logic [1:0] mask, input logic [W-1:0] a0,
                        input logic [W-1:0] b0, input logic [W-1:0] a1, input logic [W-1:0] b1);
    if0.valid     = v;
    if0.chan_mask = mask;
    if0.y_a       = {a1, a0};
    if0.y_b       = {b1, b0};
  endtask

  // One clock: u1/u2 get a stream where B equals A from two samples earlier
  task automatic step();
    logic [BW-1:0] ya, yb;
    bit v;
    int unsigned c1;
    c1 = m_cyc[1];
    ya = rand_bus();
    yb = (c1 >= 2) ? ha[1][c1 - 2] : '0;
    v  = ($urandom_range(3) != 0);
    if1.y_a = ya; if1.y_b = yb; if1.valid = v; if1.chan_mask = 2'b11;
    if2.y_a = ya; if2.y_b = yb; if2.valid = v; if2.chan_mask = 2'b11;
    model_edge(0, rst0, if0.y_a, if0.y_b, if0.valid, if0.chan_mask);
    model_edge(1, rst12, ya, yb, v, 2'b11);
    model_edge(2, rst12, ya, yb, v, 2'b11);
    @(posedge clk);
    #1;
    check_inst(0, if0.armed, if0.fail, 32'(if0.mismatch_cnt), 32'(if0.first_chan),
               if0.first_cycle, if0.first_a, if0.first_b);
    check_inst(1, if1.armed, if1.fail, 32'(if1.mismatch_cnt), 32'(if1.first_chan),
               if1.first_cycle, if1.first_a, if1.first_b);
    check_inst(2, if2.armed, if2.fail, 32'(if2.mismatch_cnt), 32'(if2.first_chan),
               if2.first_cycle, if2.first_a, if2.first_b);
  endtask

  task automatic eq_cycle(input logic [1:0] mask);
    logic [W-1:0] a0, a1;
    a0 = rand_ch(); a1 = rand_ch();
    drive0(1'b1, mask, a0, a0, a1, a1);
    step();
  endtask

  initial begin
    logic [W-1:0] x0, x1, b0, b1;
    rst0 = 1'b1; rst12 = 1'b1;
    drive0(1'b1, 2'b11, '0, '0, '0, '0);
    step(); step();
    chk("reset.armed", BW'(if0.armed), '0);
    chk("reset.fail", BW'(if0.fail), '0);
    chk("reset.cnt", BW'(if0.mismatch_cnt), '0);

    // Warm-up: persistent ch0 mismatch from reset release
    rst0 = 1'b0; rst12 = 1'b0;
    drive0(1'b1, 2'b11, 91'd1, 91'd2, 91'd3, 91'd3);
    for (int i = 0; i < 3; i++) step();
    chk("warm.armed_e3", BW'(if0.armed), '0);
    step();
    chk("warm.armed_e4", BW'(if0.armed), BW'(1));
    chk("warm.fail_e4", BW'(if0.fail), '0);
    step();
    chk("warm.fail_e5", BW'(if0.fail), BW'(1));
    chk("warm.cnt_e5", BW'(if0.mismatch_cnt), BW'(1));
    chk("warm.first_cycle", BW'(if0.first_cycle), BW'(4));

    // Multi-channel capture: ch1 at cyc 10 (5 vs 7), ch0 at cyc 12
    rst0 = 1'b1; step(); rst0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      x0 = rand_ch(); x1 = rand_ch();
      b0 = x0; b1 = x1;
      if (i == 10) begin x1 = 91'h5; b1 = 91'h7; end
      if (i == 12) b0 = x0 ^ 91'd1;
      drive0(1'b1, 2'b11, x0, b0, x1, b1);
      step();
    end
    chk("multi.first_chan", BW'(if0.first_chan), BW'(1));
    chk("multi.first_a", BW'(if0.first_a), BW'(5));
    chk("multi.first_b", BW'(if0.first_b), BW'(7));
    chk("multi.first_cycle", BW'(if0.first_cycle), BW'(10));
    chk("multi.cnt", BW'(if0.mismatch_cnt), BW'(2));

    // Masking and valid: none of these may register
    rst0 = 1'b1; step(); rst0 = 1'b0;
    for (int i = 0; i < 10; i++) eq_cycle(2'b11);
    drive0(1'b1, 2'b10, 91'd1, 91'd2, 91'd3, 91'd3); step();
    drive0(1'b1, 2'b01, 91'd1, 91'd1, 91'd3, 91'd4); step();
    drive0(1'b0, 2'b11, 91'd1, 91'd2, 91'd3, 91'd4); step();
    drive0(1'b1, 2'b00, 91'd1, 91'd2, 91'd3, 91'd4); step();
    chk("mask.fail", BW'(if0.fail), '0);
    chk("mask.cnt", BW'(if0.mismatch_cnt), '0);

    // Saturation: 10 consecutive ch1 mismatches starting at cyc 14
    drive0(1'b1, 2'b11, 91'd9, 91'd9, 91'h1234, 91'h4321); step();
    for (int i = 0; i < 9; i++) begin
      x1 = rand_ch();
      drive0(1'b1, 2'b11, 91'd9, 91'd9, x1, ~x1);
      step();
    end
    chk("sat.cnt", BW'(if0.mismatch_cnt), BW'(7));
    eq_cycle(2'b11);
    chk("sat.cnt_hold", BW'(if0.mismatch_cnt), BW'(7));
    chk("sat.fail", BW'(if0.fail), BW'(1));
    chk("sat.first_a", BW'(if0.first_a), BW'(91'h1234));
    chk("sat.first_b", BW'(if0.first_b), BW'(91'h4321));
    chk("sat.first_cycle", BW'(if0.first_cycle), BW'(14));

    // Mid-run reset clears everything; armed re-rises after WARMUP edges
    rst0 = 1'b1; step(); rst0 = 1'b0;
    chk("midrst.fail", BW'(if0.fail), '0);
    chk("midrst.cnt", BW'(if0.mismatch_cnt), '0);
    chk("midrst.first_a", BW'(if0.first_a), '0);
    chk("midrst.first_cycle", BW'(if0.first_cycle), '0);
    drive0(1'b1, 2'b11, 91'd1, 91'd2, 91'd1, 91'd2);
    for (int i = 0; i < 3; i++) step();
    chk("midrst.armed_e3", BW'(if0.armed), '0);
    step();
    chk("midrst.armed_e4", BW'(if0.armed), BW'(1));

    // Random traffic with occasional resets, checked against the model
    for (int i = 0; i < 80; i++) begin
      x0 = rand_ch(); x1 = rand_ch();
      b0 = ($urandom_range(3) == 0) ? x0 ^ (91'd1 << $urandom_range(90)) : x0;
      b1 = ($urandom_range(3) == 0) ? x1 ^ (91'd1 << $urandom_range(90)) : x1;
      drive0(($urandom_range(3) != 0), 2'($urandom_range(3)), x0, b0, x1, b1);
      rst0 = ($urandom_range(39) == 0);
      step();
    end
    rst0 = 1'b0;

    chk("align.u1_fail", BW'(if1.fail), '0);
    chk("align.u2_fail", BW'(if2.fail), BW'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
